prod_accumulator: RTL

- Streaming accumulator placed directly downstream of the 4x4 array multiplier.
- Accepts 8-bit products one per cycle over a valid/ready handshake and sums a group of them into a wider accumulator.
- Emits the group sum, term count and overflow flag over a second valid/ready handshake.
- Together with the multiplier it forms a dot-product / MAC datapath.

---
 rtl/prod_accumulator_if.sv | 36 +++
 rtl/prod_accumulator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/prod_accumulator_if.sv
// ----------------------------------------------------------------------------
// prod_accumulator_if
// Handshake bundle between a product source, the accumulator and the result
// consumer.
//   in_valid / in_ready / in_prod / in_last : product stream into the block
//   out_valid / out_ready / out_sum / out_count / out_ovf : group result stream
// Modports:
//   master : the environment side (drives products, accepts results)
//   slave  : the accumulator side
// ----------------------------------------------------------------------------
interface prod_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/prod_accumulator.sv
// ----------------------------------------------------------------------------
// prod_accumulator
// Streaming accumulator sitting behind the array multiplier. Products arrive
// one per cycle over a valid/ready handshake and are summed into a wider
// accumulator; a group closes on in_last or after MAX_TERMS products, and the
// sum, term count and overflow flag are then presented on the result
// handshake until the consumer takes them.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : prod_accumulator_if.slave (product input + result output)
//   busy   : a group is partially accumulated or a result is pending
// ----------------------------------------------------------------------------
module prod_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter bit SATURATE  = 1'b1,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    prod_accumulator_if.slave        bus,
    output logic                     busy
);
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q,   out_ovf_d;

    logic               accept;
    logic               close;
    logic [ACC_W:0]     sum_w;
    logic [ACC_W-1:0]   acc_add;
    logic               ovf_add;
    logic [CNT_W-1:0]   cnt_inc;

    // One extra bit on the adder exposes the carry used as the overflow flag.
    assign sum_w   = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);
    assign acc_add = (sum_w[ACC_W] && SATURATE) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    assign ovf_add = ovf_q | sum_w[ACC_W];
    assign cnt_inc = cnt_q + CNT_W'(1);

    assign accept = bus.in_valid & (state_q == ST_ACC);
    assign close  = accept & (bus.in_last | (cnt_inc == CNT_W'(MAX_TERMS)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ST_ACC: begin
                if (close) begin
                    // Result registers are loaded with the post-add values so
                    // the closing product is included in the reported group.
                    out_sum_d   = acc_add;
                    out_count_d = cnt_inc;
                    out_ovf_d   = ovf_add;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_OUT;
                end else if (accept) begin
                    acc_d = acc_add;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_add;
                end
            end
            ST_OUT: begin
                // No bypass: input stays stalled for the handshake cycle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (cnt_q != '0) | (state_q == ST_OUT);

endmodule
